// File: rtl/knop_pkg.sv
// knop_pkg: register addresses and ID constant shared by the knop input port.
package knop_pkg;
  localparam logic [1:0] KNOP_ADDR_LEVEL = 2'd0;
  localparam logic [1:0] KNOP_ADDR_RISE = 2'd1;
  localparam logic [1:0] KNOP_ADDR_FALL = 2'd2;
  localparam logic [1:0] KNOP_ADDR_ID = 2'd3;
  localparam logic [31:0] KNOP_ID = 32'h4B4E_4F50;
endpackage

// File: rtl/knop_debounce_bit.sv
// knop_debounce_bit: two-flop synchroniser plus counter debounce for one button bit.
module knop_debounce_bit #(
  parameter int MAX_COUNT = 100000
) (
  input  logic clk_in,
  input  logic reset,
  input  logic din_i,
  output logic stable_o
);
  localparam int CW = $clog2(MAX_COUNT);
  logic sync1_q, sync2_q, stable_q, stable_d, hit;
  logic [CW-1:0] cnt_q, cnt_d;
  assign hit = cnt_q == CW'(MAX_COUNT - 1);
  always_comb begin
    cnt_d = (sync2_q == stable_q || hit) ? '0 : cnt_q + 1'b1;
    stable_d = (sync2_q != stable_q && hit) ? sync2_q : stable_q;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      stable_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      stable_q <= stable_d;
      cnt_q <= cnt_d;
    end
  end
  assign stable_o = stable_q;
endmodule

// File: rtl/knop_input_port.sv
// knop_input_port: debounced push-button peripheral with sticky edge events, irq and read port.
// Define KNOP_FALL_EDGE_EN to add the release-event register at addr 2.
module knop_input_port
  import knop_pkg::*;
#(
  parameter int MAX_COUNT = 100000,
  parameter int KNOP_W = 4
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [KNOP_W-1:0] knop,
  input  logic              rd_en,
  input  logic [1:0]        rd_addr,
  output logic [31:0]       rd_data,
  output logic              irq,
  output logic [KNOP_W-1:0] knop_level
);
  logic [KNOP_W-1:0] stable, stable_q, rise_pend_q, rise_pend_d, fall_pend;
  logic [31:0] rd_data_q, rd_data_d;
  for (genvar i = 0; i < KNOP_W; i++) begin : g_db
    knop_debounce_bit #(.MAX_COUNT(MAX_COUNT)) u_db (
      .clk_in  (clk_in),
      .reset   (reset),
      .din_i   (knop[i]),
      .stable_o(stable[i])
    );
  end
  // A clearing read drops only the old bits; a same-cycle edge is ORed back in, so set wins.
  always_comb begin
    rise_pend_d = ((rd_en && rd_addr == KNOP_ADDR_RISE) ? '0 : rise_pend_q) | (stable & ~stable_q);
    rd_data_d = !rd_en ? rd_data_q :
                rd_addr == KNOP_ADDR_LEVEL ? 32'(stable) :
                rd_addr == KNOP_ADDR_RISE ? 32'(rise_pend_q) :
                rd_addr == KNOP_ADDR_FALL ? 32'(fall_pend) : KNOP_ID;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      stable_q <= '0;
      rise_pend_q <= '0;
      rd_data_q <= '0;
    end else begin
      stable_q <= stable;
      rise_pend_q <= rise_pend_d;
      rd_data_q <= rd_data_d;
    end
  end
`ifdef KNOP_FALL_EDGE_EN
  logic [KNOP_W-1:0] fall_pend_q, fall_pend_d;
  always_comb fall_pend_d = ((rd_en && rd_addr == KNOP_ADDR_FALL) ? '0 : fall_pend_q) | (~stable & stable_q);
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) fall_pend_q <= '0;
    else fall_pend_q <= fall_pend_d;
  end
  assign fall_pend = fall_pend_q;
`else
  assign fall_pend = '0;
`endif
  assign rd_data = rd_data_q;
  assign irq = |rise_pend_q | |fall_pend;
  assign knop_level = stable;
endmodule

// File: tb/tb_knop_input_port.sv
// tb_knop_input_port: directed checks of debounce, edge pending, clear-on-read and ID.
module tb_knop_input_port;
  logic clk_in = 1'b0, reset = 1'b1, rd_en = 1'b0;
  logic [3:0] knop = 4'h0;
  logic [1:0] rd_addr = 2'd0;
  logic [31:0] rd_data;
  logic irq;
  logic [3:0] knop_level;
  int checks = 0, failures = 0;

  knop_input_port #(.MAX_COUNT(4), .KNOP_W(4)) dut (
    .clk_in(clk_in), .reset(reset), .knop(knop), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .irq(irq), .knop_level(knop_level)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #10;
    reset = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    rd_en = 1'b1;
    rd_addr = a;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    tick(1);
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL reset_level got=%h exp=0", knop_level); end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_press;
    do_reset;
    knop = 4'b0001;
    tick(5);
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL press_level_early got=%h exp=0", knop_level); end
    tick(1);
    checks++; if (knop_level !== 4'h1) begin failures++; $display("FAIL press_level got=%h exp=1", knop_level); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_early got=%b exp=0", irq); end
    tick(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL press_irq got=%b exp=1", irq); end
    rd(2'd1);
    checks++; if (rd_data !== 32'h1) begin failures++; $display("FAIL press_read1 got=%h exp=1", rd_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL press_irq_clr got=%b exp=0", irq); end
    rd(2'd1);
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL press_read2 got=%h exp=0", rd_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL press_irq2 got=%b exp=0", irq); end
  endtask

  task automatic test_glitch;
    do_reset;
    knop = 4'b0010;
    tick(3);
    knop = 4'b0000;
    tick(10);
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL glitch_level got=%h exp=0", knop_level); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL glitch_irq got=%b exp=0", irq); end
    rd(2'd1);
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL glitch_rise got=%h exp=0", rd_data); end
  endtask

  task automatic test_sweep;
    do_reset;
    for (int v = 1; v < 16; v++) begin
      knop = 4'(v);
      tick(20);
      rd(2'd0);
      checks++; if (rd_data !== 32'(v)) begin failures++; $display("FAIL sweep_level got=%h exp=%h", rd_data, 32'(v)); end
    end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL sweep_irq got=%b exp=1", irq); end
    rd(2'd1);
    checks++; if (rd_data !== 32'hF) begin failures++; $display("FAIL sweep_rise got=%h exp=f", rd_data); end
  endtask

  task automatic test_race;
    do_reset;
    knop = 4'b0001;
    tick(8);
    knop = 4'b0101;
    tick(6);
    rd(2'd1);
    checks++; if (rd_data !== 32'h1) begin failures++; $display("FAIL race_read got=%h exp=1", rd_data); end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL race_irq got=%b exp=1", irq); end
    rd(2'd1);
    checks++; if (rd_data !== 32'h4) begin failures++; $display("FAIL race_after got=%h exp=4", rd_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL race_irq_clr got=%b exp=0", irq); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    knop = 4'b1000;
    tick(3);
    do_reset;
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL midrst_level0 got=%h exp=0", knop_level); end
    tick(5);
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL midrst_level5 got=%h exp=0", knop_level); end
    tick(1);
    checks++; if (knop_level !== 4'h8) begin failures++; $display("FAIL midrst_level6 got=%h exp=8", knop_level); end
  endtask

  task automatic test_fall;
    do_reset;
    knop = 4'b1000;
    tick(8);
    rd(2'd1);
    checks++; if (rd_data !== 32'h8) begin failures++; $display("FAIL fall_rise got=%h exp=8", rd_data); end
    knop = 4'b0000;
    tick(8);
    checks++; if (knop_level !== 4'h0) begin failures++; $display("FAIL fall_level got=%h exp=0", knop_level); end
`ifdef KNOP_FALL_EDGE_EN
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_irq got=%b exp=1", irq); end
    tick(5);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_irq_held got=%b exp=1", irq); end
    rd(2'd2);
    checks++; if (rd_data !== 32'h8) begin failures++; $display("FAIL fall_read got=%h exp=8", rd_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_irq_clr got=%b exp=0", irq); end
`else
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL fall_irq got=%b exp=0", irq); end
    rd(2'd2);
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL fall_read got=%h exp=0", rd_data); end
`endif
  endtask

  task automatic test_id;
    rd(2'd3);
    checks++; if (rd_data !== 32'h4B4E_4F50) begin failures++; $display("FAIL id_read got=%h exp=4b4e4f50", rd_data); end
    tick(3);
    checks++; if (rd_data !== 32'h4B4E_4F50) begin failures++; $display("FAIL id_hold got=%h exp=4b4e4f50", rd_data); end
    do_reset;
    checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL id_reset got=%h exp=0", rd_data); end
  endtask

  initial begin
    test_reset;
    test_press;
    test_glitch;
    test_sweep;
    test_race;
    test_reset_mid;
    test_fall;
    test_id;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
